// File: rtl/manchester_transmitter.sv
// Manchester line transmitter.
// Frames a variable-length byte stream as: PREAMBLE_BITS ones, payload bytes
// (MSB first), then one idle bit period held low. Bit 0 is high-then-low,
// bit 1 is low-then-high, and the line rests low. A one-byte holding register
// with a valid/ready handshake feeds the shift register. The frame continues
// while that register is refilled before each byte boundary, up to
// MAX_FRAME_BYTES bytes.
module manchester_transmitter #(
    parameter int HALF_BIT_CYCLES = 8,
    parameter int PREAMBLE_BITS   = 8,
    parameter int MAX_FRAME_BYTES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       manchester_out,
    output logic       busy,
    output logic       transmission_begin,
    output logic       frame_done
);

    localparam int HC_W = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam int PC_W = $clog2(PREAMBLE_BITS + 1);
    localparam int BC_W = $clog2(MAX_FRAME_BYTES + 1);

    localparam logic [HC_W-1:0] HALF_LAST = HC_W'(HALF_BIT_CYCLES - 1);
    localparam logic [PC_W-1:0] PRE_LAST  = PC_W'(PREAMBLE_BITS - 1);
    localparam logic [BC_W-1:0] BYTE_CAP  = BC_W'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_TRAIL    = 2'd3
    } state_t;

    state_t          r_state;
    logic [HC_W-1:0] r_half_cnt;
    logic            r_phase;
    logic [2:0]      r_bit_idx;
    logic [PC_W-1:0] r_pre_cnt;
    logic [BC_W-1:0] r_byte_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_hold;
    logic            r_hold_full;
    logic            r_manchester;
    logic            r_busy;
    logic            r_begin;
    logic            r_done;

    state_t          w_state_nxt;
    logic [HC_W-1:0] w_half_nxt;
    logic            w_phase_nxt;
    logic [2:0]      w_bit_nxt;
    logic [PC_W-1:0] w_pre_nxt;
    logic [BC_W-1:0] w_byte_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_load;
    logic            w_begin;
    logic            w_done;
    logic            w_line;
    logic            w_half_end;
    logic            w_bit_end;
    logic            w_accept;

    // Ready is the empty flag of the holding register, gated off during reset.
    assign data_ready = !r_hold_full && !reset;
    assign w_accept   = data_valid && data_ready;
    assign w_half_end = (r_half_cnt == HALF_LAST);
    assign w_bit_end  = w_half_end && r_phase;

    assign manchester_out     = r_manchester;
    assign busy               = r_busy;
    assign transmission_begin = r_begin;
    assign frame_done         = r_done;

    // Next-state logic: half-bit timing, framing sequence and byte loads.
    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half_cnt;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit_idx;
        w_pre_nxt   = r_pre_cnt;
        w_byte_nxt  = r_byte_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_begin     = 1'b0;
        w_done      = 1'b0;

        // Half-bit timebase runs in every active state; the phase flips at each half-bit end.
        if (r_state != ST_IDLE) begin
            if (w_half_end) begin
                w_half_nxt  = {HC_W{1'b0}};
                w_phase_nxt = ~r_phase;
            end else begin
                w_half_nxt  = r_half_cnt + HC_W'(1);
            end
        end else begin
            w_half_nxt = r_half_cnt;
        end

        case (r_state)
            ST_IDLE: begin
                // A byte already waiting, or arriving now, starts a frame.
                if (r_hold_full || w_accept) begin
                    w_state_nxt = ST_PREAMBLE;
                    w_half_nxt  = {HC_W{1'b0}};
                    w_phase_nxt = 1'b0;
                    w_pre_nxt   = {PC_W{1'b0}};
                    w_bit_nxt   = 3'd0;
                    w_begin     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (w_bit_end && (r_pre_cnt == PRE_LAST)) begin
                    w_state_nxt = ST_DATA;
                    w_load      = 1'b1;
                    w_shift_nxt = r_hold;
                    w_byte_nxt  = BC_W'(1);
                    w_bit_nxt   = 3'd0;
                end else if (w_bit_end) begin
                    w_pre_nxt = r_pre_cnt + PC_W'(1);
                end else begin
                    w_state_nxt = ST_PREAMBLE;
                end
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    // Byte boundary: chain the next byte only if it was already held.
                    if (r_hold_full && (r_byte_cnt < BYTE_CAP)) begin
                        w_load      = 1'b1;
                        w_shift_nxt = r_hold;
                        w_byte_nxt  = r_byte_cnt + BC_W'(1);
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_TRAIL;
                    end
                end else if (w_bit_end) begin
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    w_shift_nxt = {r_shift[6:0], 1'b0};
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_TRAIL: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = ST_TRAIL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle: first half is the inverted bit, second half the bit.
    always_comb begin
        w_line = 1'b0;
        case (w_state_nxt)
            ST_PREAMBLE: w_line = w_phase_nxt;
            ST_DATA:     w_line = ~(w_phase_nxt ^ w_shift_nxt[7]);
            default:     w_line = 1'b0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_half_cnt   <= {HC_W{1'b0}};
            r_phase      <= 1'b0;
            r_bit_idx    <= 3'd0;
            r_pre_cnt    <= {PC_W{1'b0}};
            r_byte_cnt   <= {BC_W{1'b0}};
            r_shift      <= 8'd0;
            r_manchester <= 1'b0;
            r_busy       <= 1'b0;
            r_begin      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_half_cnt   <= w_half_nxt;
            r_phase      <= w_phase_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_pre_cnt    <= w_pre_nxt;
            r_byte_cnt   <= w_byte_nxt;
            r_shift      <= w_shift_nxt;
            r_manchester <= w_line;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_begin      <= w_begin;
            r_done       <= w_done;
        end
    end

    // Holding register: filled by the handshake, emptied when copied to the shifter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold      <= 8'd0;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
        end else begin
            r_hold_full <= r_hold_full;
        end
    end

endmodule

// File: tb/tb_manchester_transmitter.sv
// Self-checking bench for manchester_transmitter (H=4, P=8, cap 16).
// Every cycle's outputs are recorded at the falling edge; frames are compared
// against a waveform built directly from the line-coding rules.
module tb_manchester_transmitter;

    localparam int H = 4;
    localparam int P = 8;
    localparam int M = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       manchester_out;
    logic       busy;
    logic       transmission_begin;
    logic       frame_done;

    manchester_transmitter #(
        .HALF_BIT_CYCLES(H),
        .PREAMBLE_BITS(P),
        .MAX_FRAME_BYTES(M)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .manchester_out(manchester_out),
        .busy(busy),
        .transmission_begin(transmission_begin),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic line;
        logic bsy;
        logic tb;
        logic fd;
    } samp_t;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  data;
        logic [15:0] halves;
    } vec_t;

    samp_t rec[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    exp_wave[$];

    // rec[k] holds the outputs seen after rising edge k
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) rec.push_back({manchester_out, busy, transmission_begin, frame_done});

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference line coding: bit b -> H cycles of !b then H cycles of b.
    function automatic void add_bit(input bit b);
        repeat (H) exp_wave.push_back(!b);
        repeat (H) exp_wave.push_back(b);
    endfunction

    function automatic void build_wave(input bq_t bytes);
        exp_wave.delete();
        repeat (P) add_bit(1'b1);
        foreach (bytes[j]) begin
            for (int i = 7; i >= 0; i--) add_bit(bytes[j][i]);
        end
        repeat (2 * H) exp_wave.push_back(1'b0);
    endfunction

    function automatic int frame_len(input int nbytes);
        return 2 * H * (P + 8 * nbytes + 1);
    endfunction

    // Offer one byte from a falling edge; returns the index of the accepting edge.
    task automatic push(input logic [7:0] b, output int acc);
        int waited;
        waited = 0;
        data_in = b;
        data_valid = 1'b1;
        while (!data_ready && waited < 3000) begin
            @(negedge clock);
            waited++;
        end
        if (!data_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push timeout: data_ready stayed 0 for %0d cycles, expected 1", waited);
            data_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clock);
            @(negedge clock);
            acc = cyc;
            data_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clock);
            if (frame_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done timeout: got none in 5000 cycles, expected a pulse");
        end
    endtask

    task automatic check_frame(input int start, input bq_t bytes, input string name);
        int len, mism, nbusy, extra, ps;
        logic [7:0] b;
        len = frame_len(bytes.size());
        if (start < 1 || rec.size() <= start + len) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s record: got start %0d size %0d, expected frame of %0d cycles", name, start, rec.size(), len);
            return;
        end
        chk($sformatf("%s begin", name), rec[start].tb, 1);
        chk($sformatf("%s idle before", name), rec[start - 1].bsy, 0);
        build_wave(bytes);
        mism = 0;
        nbusy = 0;
        extra = 0;
        for (int i = 0; i < len; i++) begin
            if (rec[start + i].line !== exp_wave[i]) mism++;
            if (rec[start + i].bsy === 1'b1) nbusy++;
            if (rec[start + i].fd !== 1'b0) extra++;
            if (i > 0 && rec[start + i].tb !== 1'b0) extra++;
        end
        chk($sformatf("%s wave mismatches", name), mism, 0);
        chk($sformatf("%s busy cycles", name), nbusy, len);
        chk($sformatf("%s busy after", name), rec[start + len].bsy, 0);
        chk($sformatf("%s stray pulses", name), extra, 0);
        chk($sformatf("%s frame_done", name), rec[start + len].fd, 1);
        ps = start + 2 * H * P;
        foreach (bytes[j]) begin
            b = 8'd0;
            for (int i = 0; i < 8; i++) b = {b[6:0], rec[ps + (j * 8 + i) * 2 * H + H].line};
            chk($sformatf("%s decoded byte %0d", name, j), b, bytes[j]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        bq_t  q;
        int   a, a2, d, d2, cnt, n;
        logic [15:0] halves;

        tbl[0] = '{8'hA5, 16'h6699};
        tbl[1] = '{8'h00, 16'hAAAA};
        tbl[2] = '{8'hFF, 16'h5555};
        tbl[3] = '{8'h3C, 16'hA55A};
        tbl[4] = '{8'h81, 16'h6AA9};

        rec.push_back(4'b0000);

        // Reset held with data_valid high: nothing moves, nothing accepted.
        reset = 1'b1;
        data_valid = 1'b1;
        data_in = 8'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("reset line", manchester_out, 0);
            chk("reset busy", busy, 0);
            chk("reset ready", data_ready, 0);
        end
        reset = 1'b0;
        data_valid = 1'b0;
        @(negedge clock);
        chk("ready after release", data_ready, 1);
        chk("busy after release", busy, 0);
        @(negedge clock);

        // Single-byte frames with hand-computed half-bit patterns.
        for (int i = 0; i < 5; i++) begin
            q.delete();
            q.push_back(tbl[i].data);
            push(tbl[i].data, a);
            wait_done(d);
            repeat (2) @(negedge clock);
            chk($sformatf("single %0h done time", tbl[i].data), d, a + frame_len(1));
            check_frame(a, q, $sformatf("single %0h", tbl[i].data));
            halves = 16'd0;
            for (int h = 0; h < 16; h++) halves = {halves[14:0], rec[a + 2 * H * P + h * H].line};
            chk($sformatf("single %0h halves", tbl[i].data), halves, tbl[i].halves);
        end

        // Back-to-back bytes merge into one gapless frame.
        q.delete();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        push(8'h00, a);
        push(8'hFF, a2);
        chk("b2b accept window", (a2 > a + 2 * H * P) && (a2 < a + 2 * H * P + 16 * H), 1);
        wait_done(d);
        repeat (2) @(negedge clock);
        chk("b2b done time", d, a + frame_len(2));
        check_frame(a, q, "b2b");

        // Second byte arriving on the bit-7 decision edge opens a new frame.
        push(8'h3C, a);
        while (cyc < a + 2 * H * P + 16 * H - 1) @(negedge clock);
        push(8'h96, a2);
        chk("underflow accept edge", a2, a + 2 * H * P + 16 * H);
        wait_done(d);
        wait_done(d2);
        repeat (2) @(negedge clock);
        chk("underflow done time", d, a + frame_len(1));
        q.delete();
        q.push_back(8'h3C);
        check_frame(a, q, "underflow f1");
        q.delete();
        q.push_back(8'h96);
        check_frame(d + 1, q, "underflow f2");

        // Seventeen streamed bytes: cap of sixteen, remainder in a second frame.
        q.delete();
        for (int k = 0; k < 17; k++) q.push_back(8'($urandom));
        push(q[0], a);
        for (int k = 1; k < 17; k++) push(q[k], a2);
        wait_done(d);
        wait_done(d2);
        repeat (2) @(negedge clock);
        chk("cap done time", d, a + frame_len(M));
        begin
            bq_t q1, q2;
            for (int k = 0; k < 16; k++) q1.push_back(q[k]);
            q2.push_back(q[16]);
            check_frame(a, q1, "cap f1");
            check_frame(d + 1, q2, "cap f2");
        end

        // Reset during bit 3 of byte 0 aborts silently.
        push(8'hC3, a);
        while (cyc < a + 2 * H * P + 3 * 2 * H + 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort line", manchester_out, 0);
        chk("abort busy", busy, 0);
        chk("abort ready", data_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (frame_done || busy) cnt++;
        end
        chk("abort quiet", cnt, 0);
        q.delete();
        q.push_back(8'h5A);
        push(8'h5A, a);
        wait_done(d);
        repeat (2) @(negedge clock);
        check_frame(a, q, "after abort");

        // Randomized bursts with small inter-byte gaps.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            push(q[0], a);
            for (int k = 1; k < n; k++) begin
                repeat ($urandom_range(0, 20)) @(negedge clock);
                push(q[k], a2);
            end
            wait_done(d);
            repeat (2) @(negedge clock);
            chk($sformatf("rand%0d done time", r), d, a + frame_len(n));
            check_frame(a, q, $sformatf("rand%0d", r));
            repeat ($urandom_range(0, 5)) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/manchester_transmitter.md
# manchester_transmitter

Serialises bytes into a Manchester-encoded line signal framed with a fixed preamble and a trailing idle bit. It is the transmit counterpart of the chip's Manchester receive path (edge detect, clock/data recovery, addressed byte capture). Frames are variable-length: they run while the upstream source keeps the one-byte holding register filled, up to MAX_FRAME_BYTES. A one-byte holding register with a valid/ready handshake decouples the byte source from the bit timing.

## Interface
- HALF_BIT_CYCLES, default 8: clock cycles per Manchester half-bit. A bit period is 2*HALF_BIT_CYCLES. Legal range is ≥1.
- PREAMBLE_BITS, default 8: number of preamble bits sent before each frame's payload. Legal range is ≥1.
- MAX_FRAME_BYTES, default 16: payload byte cap per frame. Matches the receiver's 4-bit address space.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  8  payload byte.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  the holding register is empty. Equals !hold_full. Forced 0 while reset is high.
- manchester_out  out  1  registered line output.
- busy  out  1  high in PREAMBLE, DATA and TRAIL.
- transmission_begin  out  1  one-cycle pulse in the first cycle of a preamble.
- frame_done  out  1  one-cycle pulse in the first IDLE cycle after TRAIL.

## Operation
Encoding follows IEEE 802.3:
- bit 0 = high for HALF_BIT_CYCLES, then low for HALF_BIT_CYCLES.
- bit 1 = low, then high.
- Idle line level is 0.

Preamble and payload format:
- Preamble is PREAMBLE_BITS consecutive 1 bits.
- Each bit's mid-bit rising edge gives the receiver edges to lock to.
- Payload is sent byte 0 first, MSB first within each byte.

Handshake:
- A byte transfers on any edge where data_valid && data_ready are both high.
- The byte is stored in the holding register and hold_full is set.
- hold_full is cleared when the byte is loaded into the shift register.

State machine:
- IDLE:
  - manchester_out=0, busy=0.
  - Moves to PREAMBLE on the edge where hold_full is set, or immediately if hold_full is already set.
  - Lasts at least 1 cycle after TRAIL.
- PREAMBLE:
  - Sends PREAMBLE_BITS ones.
  - On the final edge, loads the shift register from the holding register, clears hold_full, sets byte_count=1 and moves to DATA.
- DATA:
  - Sends 8 bits of the shift register.
  - On the edge ending bit 7, checks for a next byte.
  - If hold_full && byte_count < MAX_FRAME_BYTES: load the next byte, clear hold_full, increment byte_count, stay in DATA. The bit stream stays gapless.
  - Otherwise (underflow or cap reached): move to TRAIL.
- TRAIL:
  - manchester_out=0 for 2*HALF_BIT_CYCLES cycles, then IDLE.
  - frame_done pulses in the first IDLE cycle.

Counter widths:
- Half-bit counter: $clog2(HALF_BIT_CYCLES) bits, minimum 1. Counts 0..HALF_BIT_CYCLES-1 and wraps.
- Phase flag: 1 bit.
- Bit index: 3 bits.
- Preamble counter: $clog2(PREAMBLE_BITS+1) bits.
- byte_count: $clog2(MAX_FRAME_BYTES+1) bits.

Boundary rules:
- A byte accepted on the same edge as the bit-7 decision is not counted for the current frame. It remains in the holding register and starts the next frame after TRAIL/IDLE.
- A byte accepted during TRAIL or at the cap is held and starts the next frame.
- reset has priority over everything. On the next edge the block goes to IDLE with hold_full=0 and all counters 0. No frame_done is issued for the aborted frame.

## Timing
Reset values:
- manchester_out=0, busy=0, transmission_begin=0, frame_done=0.
- data_ready=0 while reset is high, 1 in the first cycle after release.

Frame timing, with acceptance from IDLE at edge T and H=HALF_BIT_CYCLES:
- busy=1 and transmission_begin=1 during cycle T+1.
- First preamble half-bit (low) occupies cycles T+1..T+H.
- Payload starts at cycle T+1+2H*PREAMBLE_BITS.

Throughput:
- data_ready rises 1 cycle after each load.
- Upstream has 16H-1 cycles to refill before the next decision edge.
- Total frame length = 2H*(PREAMBLE_BITS + 8N + 1) cycles of busy, where N is the number of payload bytes.

## Test plan
- Reset: hold reset 3 cycles with data_valid=1. Required: manchester_out=0, busy=0, data_ready=0, no transfer. data_ready=1 in the cycle after release.
- Single byte (H=4, P=8): send 0xA5, accepted at T.
  - transmission_begin at T+1.
  - Cycles T+1..T+64: repeating 0000_1111.
  - Cycles T+65..T+128: bits 1,0,1,0,0,1,0,1.
  - Cycles T+129..T+136: low.
  - busy=1 over T+1..T+136; frame_done at T+137.
- Back-to-back bytes: 0x00 then 0xFF with data_valid held high.
  - Second byte accepted at T+66.
  - Payload is 8×(1111_0000) then 8×(0000_1111) with no gap.
  - One frame, 2 bytes, one frame_done.
- Underflow: 0x3C, then the second byte presented exactly on the bit-7 decision edge.
  - Frame ends after 1 byte.
  - The second byte starts a new frame with a fresh preamble, 1 cycle after frame_done.
- Cap: stream 17 bytes continuously.
  - Exactly 16 payload bytes, then TRAIL and frame_done.
  - Byte 17 is sent in a second frame.
  - Decoded payload matches the input order.
- Reset mid-DATA: assert reset during bit 3 of byte 0.
  - Next cycle: manchester_out=0, busy=0, data_ready=0.
  - No frame_done.
  - A fresh byte afterwards produces a complete normal frame.
